// File: rtl/edge_detection_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detection_pkg
//  Description : Shared pixel/window types and constants for the edge
//                detection pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package edge_detection_pkg;

  localparam int PIXEL_WIDTH = 8;
  localparam int WINDOW_SIZE = 3;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  typedef pixel_t [8:0]           window_t;

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer
//  Description : DEPTH-deep delay line built as a circular RAM. data_out is
//                the word pushed exactly DEPTH shifts ago.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;

  // Read-before-write: the slot about to be overwritten holds the oldest word.
  assign data_out = r_mem[r_ptr];

  // Pointer advances on every shift and wraps explicitly at DEPTH-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (shift_en) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  // Storage is not reset; stale contents are masked by window validity.
  always_ff @(posedge clock) begin
    if (shift_en) begin
      r_mem[r_ptr] <= data_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/grayscale_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : grayscale_window_buffer
//  Description : Builds a 3x3 neighbourhood window from a raster grayscale
//                stream using two line buffers; flags only fully-interior
//                windows and reports the window centre position.
//  Revision    : 1.0 - initial release
// ============================================================================
module grayscale_window_buffer #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int PIXEL_WIDTH  = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            frame_start,
  input  logic                            pixel_in_valid,
  input  logic [PIXEL_WIDTH-1:0]          pixel_in,
  output logic [9*PIXEL_WIDTH-1:0]        window_out,
  output logic                            window_valid,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  center_col,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] center_row,
  output logic                            frame_done
);

  import edge_detection_pkg::WINDOW_SIZE;

  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT);

  logic [COL_W-1:0]       r_col;
  logic [ROW_W-1:0]       r_row;
  logic [PIXEL_WIDTH-1:0] r_win  [WINDOW_SIZE*WINDOW_SIZE];
  logic [PIXEL_WIDTH-1:0] w_feed [WINDOW_SIZE];
  logic [PIXEL_WIDTH-1:0] w_lb1;
  logic [PIXEL_WIDTH-1:0] w_lb2;
  logic                   w_accept;
  logic [COL_W-1:0]       w_col;
  logic [ROW_W-1:0]       w_row;
  logic                   w_col_last;
  logic                   w_row_last;
  logic                   w_interior;

  assign w_accept   = enable & pixel_in_valid;
  // frame_start redefines the current pixel as (0,0) in the same cycle.
  assign w_col      = frame_start ? '0 : r_col;
  assign w_row      = frame_start ? '0 : r_row;
  assign w_col_last = (w_col == COL_W'(IMAGE_WIDTH - 1));
  assign w_row_last = (w_row == ROW_W'(IMAGE_HEIGHT - 1));
  assign w_interior = (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));

  line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb1 (
    .clock    (clock),
    .reset    (reset),
    .shift_en (w_accept),
    .data_in  (pixel_in),
    .data_out (w_lb1)
  );

  line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb2 (
    .clock    (clock),
    .reset    (reset),
    .shift_en (w_accept),
    .data_in  (w_lb1),
    .data_out (w_lb2)
  );

  // Top row is fed from two rows back, bottom row from the live pixel.
  assign w_feed[0] = w_lb2;
  assign w_feed[1] = w_lb1;
  assign w_feed[2] = pixel_in;

  // Raster position tracking with explicit wrap compares.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : w_row + ROW_W'(1);
      end else begin
        r_col <= w_col + COL_W'(1);
        r_row <= w_row;
      end
    end else if (frame_start) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  // Window rows shift left on accept; newest sample enters the right column.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < WINDOW_SIZE*WINDOW_SIZE; k++) begin
        r_win[k] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < WINDOW_SIZE; i++) begin
        for (int j = 0; j < WINDOW_SIZE-1; j++) begin
          r_win[i*WINDOW_SIZE+j] <= r_win[i*WINDOW_SIZE+j+1];
        end
        r_win[i*WINDOW_SIZE+WINDOW_SIZE-1] <= w_feed[i];
      end
    end
  end

  // Valid/done pulses and centre coordinates, registered with the window.
  always_ff @(posedge clock) begin
    if (reset) begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      center_col   <= '0;
      center_row   <= '0;
    end else begin
      window_valid <= w_accept && w_interior;
      frame_done   <= w_accept && w_interior && w_row_last && w_col_last;
      if (w_accept && w_interior) begin
        center_col <= w_col - COL_W'(1);
        center_row <= w_row - ROW_W'(1);
      end
    end
  end

  for (genvar k = 0; k < WINDOW_SIZE*WINDOW_SIZE; k++) begin : g_pack
    assign window_out[k*PIXEL_WIDTH +: PIXEL_WIDTH] = r_win[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_grayscale_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grayscale_window_buffer
//  Description : Directed self-checking bench for grayscale_window_buffer on
//                a 4x4 frame with pixel = base + row*16 + col.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grayscale_window_buffer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          frame_start;
  logic          pixel_in_valid;
  logic [PW-1:0] pixel_in;
  logic [9*PW-1:0] window_out;
  logic          window_valid;
  logic [1:0]    center_col;
  logic [1:0]    center_row;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  grayscale_window_buffer #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .PIXEL_WIDTH (PW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .frame_start   (frame_start),
    .pixel_in_valid(pixel_in_valid),
    .pixel_in      (pixel_in),
    .window_out    (window_out),
    .window_valid  (window_valid),
    .center_col    (center_col),
    .center_row    (center_row),
    .frame_done    (frame_done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected window for the pixel at (r,c) of a frame with the given base.
  function automatic logic [9*PW-1:0] exp_window(input logic [7:0] base, input int r, input int c);
    logic [9*PW-1:0] w;
    for (int k = 0; k < 9; k++) begin
      w[k*PW +: PW] = base + 8'((r - 2 + k/3) * 16 + (c - 2 + k%3));
    end
    return w;
  endfunction

  // One clock of stimulus; outputs are stable #1 after the rising edge.
  task automatic drive(input logic [7:0] p, input logic v, input logic e, input logic fs);
    @(negedge clock);
    pixel_in       = p;
    pixel_in_valid = v;
    enable         = e;
    frame_start    = fs;
    @(posedge clock);
    #1;
  endtask

  // Streams pixels 0..last of a frame, checking every output cycle.
  task automatic test_frame(input string name, input logic [7:0] base, input bit fs_first,
                            input bit gaps, input int last,
                            output logic [9*PW-1:0] first_win, output logic [9*PW-1:0] last_win);
    int  nwin;
    bit  exp_v;
    int  r;
    int  c;
    nwin      = 0;
    first_win = '0;
    last_win  = '0;
    for (int i = 0; i <= last; i++) begin
      r = i / W;
      c = i % W;
      if (gaps) begin
        int n;
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) begin
          int sel;
          sel = $urandom_range(0, 2);
          drive(8'hEE, sel != 1, sel == 1, 1'b0);
          checks++;
          if (window_valid !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_quiet before (%0d,%0d): valid=%b done=%b required 0/0",
                     name, r, c, window_valid, frame_done);
          end
        end
      end
      drive(base + 8'(r*16 + c), 1'b1, 1'b1, fs_first && i == 0);
      exp_v = (r >= 2) && (c >= 2);
      checks++;
      if (window_valid !== exp_v) begin
        failures++;
        $display("FAIL %s valid at (%0d,%0d): got %b required %b", name, r, c, window_valid, exp_v);
      end
      checks++;
      if (frame_done !== (r == H-1 && c == W-1)) begin
        failures++;
        $display("FAIL %s frame_done at (%0d,%0d): got %b required %b",
                 name, r, c, frame_done, (r == H-1 && c == W-1));
      end
      if (exp_v) begin
        if (nwin == 0) first_win = window_out;
        last_win = window_out;
        nwin++;
        checks++;
        if (window_out !== exp_window(base, r, c)) begin
          failures++;
          $display("FAIL %s window at (%0d,%0d): got %h required %h",
                   name, r, c, window_out, exp_window(base, r, c));
        end
        checks++;
        if (center_row !== 2'(r-1) || center_col !== 2'(c-1)) begin
          failures++;
          $display("FAIL %s center at (%0d,%0d): got (%0d,%0d) required (%0d,%0d)",
                   name, r, c, center_row, center_col, r-1, c-1);
        end
      end
    end
    drive(8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (window_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s trailing_valid: got %b required 0", name, window_valid);
    end
    if (last == W*H-1) begin
      checks++;
      if (nwin != (W-2)*(H-2)) begin
        failures++;
        $display("FAIL %s window_count: got %0d required %0d", name, nwin, (W-2)*(H-2));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(8'h00, 1'b0, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    checks++;
    if (window_out !== '0 || window_valid !== 1'b0 || frame_done !== 1'b0 ||
        center_col !== 2'd0 || center_row !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: win=%h valid=%b done=%b center=(%0d,%0d) required all 0",
               window_out, window_valid, frame_done, center_row, center_col);
    end
  endtask

  task automatic test_full_frame();
    logic [9*PW-1:0] fw, lw;
    test_frame("full", 8'h00, 1'b0, 1'b0, W*H-1, fw, lw);
    checks++;
    if (fw !== 72'h22_21_20_12_11_10_02_01_00) begin
      failures++;
      $display("FAIL first_window: got %h required %h", fw, 72'h22_21_20_12_11_10_02_01_00);
    end
    checks++;
    if (lw !== 72'h33_32_31_23_22_21_13_12_11) begin
      failures++;
      $display("FAIL last_window: got %h required %h", lw, 72'h33_32_31_23_22_21_13_12_11);
    end
  endtask

  task automatic test_stall();
    logic [9*PW-1:0] fw, lw;
    test_frame("stall", 8'h00, 1'b0, 1'b1, W*H-1, fw, lw);
  endtask

  task automatic test_frame_start_abort();
    logic [9*PW-1:0] fw, lw;
    // Frame A up to (2,1): no window may appear.
    test_frame("abortA", 8'h00, 1'b1, 1'b0, 2*W+1, fw, lw);
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    checks++;
    if (window_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse_valid: got %b required 0", window_valid);
    end
    test_frame("abortB", 8'h80, 1'b0, 1'b0, W*H-1, fw, lw);
    checks++;
    if (fw !== 72'hA2_A1_A0_92_91_90_82_81_80) begin
      failures++;
      $display("FAIL abortB_first_window: got %h required %h", fw, 72'hA2_A1_A0_92_91_90_82_81_80);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9*PW-1:0] fw, lw;
    test_frame("premrst", 8'h00, 1'b1, 1'b0, 3*W+1, fw, lw);
    reset = 1'b1;
    drive(8'h00, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    checks++;
    if (window_out !== '0 || window_valid !== 1'b0 || frame_done !== 1'b0 ||
        center_col !== 2'd0 || center_row !== 2'd0) begin
      failures++;
      $display("FAIL midreset_state: win=%h valid=%b done=%b center=(%0d,%0d) required all 0",
               window_out, window_valid, frame_done, center_row, center_col);
    end
    test_frame("postrst", 8'h40, 1'b0, 1'b0, W*H-1, fw, lw);
  endtask

  task automatic test_frame_start_same_cycle();
    logic [9*PW-1:0] fw, lw;
    test_frame("prefs", 8'h55, 1'b0, 1'b0, 5, fw, lw);
    test_frame("samefs", 8'h00, 1'b1, 1'b0, W*H-1, fw, lw);
    checks++;
    if (fw !== 72'h22_21_20_12_11_10_02_01_00) begin
      failures++;
      $display("FAIL samefs_first_window: got %h required %h", fw, 72'h22_21_20_12_11_10_02_01_00);
    end
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    frame_start    = 1'b0;
    pixel_in_valid = 1'b0;
    pixel_in       = '0;
    test_reset();
    test_full_frame();
    test_stall();
    test_frame_start_abort();
    test_reset_mid_frame();
    test_frame_start_same_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
